// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin sharing of the single register-file write port
// between ALU and LSU writeback, plus a per-register busy scoreboard used by
// decode to stall on read-after-write hazards.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] chk_rs1,
    input  logic [ADDR_WIDTH-1:0] chk_rs2,
    output logic                  hazard,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

    grant_t                last_grant;
    grant_t                last_grant_next;
    logic                  alu_grant;
    logic                  lsu_grant;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;

    // Grant a lone requester directly; on a tie favour whoever did not win last.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (alu_valid && lsu_valid) begin
            if (last_grant == GRANT_ALU) begin
                lsu_grant = 1'b1;
            end else begin
                alu_grant = 1'b1;
            end
        end else begin
            alu_grant = alu_valid;
            lsu_grant = lsu_valid;
        end
    end

    assign alu_ready = alu_grant;
    assign lsu_ready = lsu_grant;

    // Select the winning request and remember the winner for the next tie.
    always_comb begin
        xfer            = alu_grant | lsu_grant;
        sel_rd          = alu_rd;
        sel_data        = alu_data;
        last_grant_next = last_grant;
        if (lsu_grant) begin
            sel_rd          = lsu_rd;
            sel_data        = lsu_data;
            last_grant_next = GRANT_LSU;
        end else if (alu_grant) begin
            last_grant_next = GRANT_ALU;
        end
    end

    // Round-robin pointer; starts at ALU so the first tie after reset goes to LSU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_ALU;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    // Registered write port; x0 writes are consumed but never enable the file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (xfer) begin
            rf_wen   <= (sel_rd != '0);
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // Busy bits clear when the write commits; a same-edge issue wins over the clear.
    always_comb begin
        busy_next = busy;
        if (rf_wen) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign hazard = ((chk_rs1 != '0) && busy[chk_rs1]) ||
                    ((chk_rs2 != '0) && busy[chk_rs2]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios with literal expectations followed by
// randomized writeback/issue traffic, all checked every cycle against a
// behavioural model of the arbiter and scoreboard.
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic [AW-1:0] chk_rs1;
    logic [AW-1:0] chk_rs2;
    logic          hazard;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .hazard    (hazard),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Behavioural model: who won last, which registers await a write, and
    // what the write port should be presenting this cycle.
    bit            m_last_lsu;
    bit            m_busy [NR];
    bit            m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic          exp_alu_ready;
    logic          exp_lsu_ready;
    logic          exp_hazard;

    always_comb begin
        exp_alu_ready = 1'b0;
        exp_lsu_ready = 1'b0;
        if (alu_valid === 1'b1 && lsu_valid === 1'b1) begin
            if (m_last_lsu) exp_alu_ready = 1'b1;
            else            exp_lsu_ready = 1'b1;
        end else begin
            exp_alu_ready = (alu_valid === 1'b1);
            exp_lsu_ready = (lsu_valid === 1'b1);
        end
        exp_hazard = ((chk_rs1 != 0) && m_busy[chk_rs1]) ||
                     ((chk_rs2 != 0) && m_busy[chk_rs2]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last_lsu <= 1'b0;
            m_wen      <= 1'b0;
            m_waddr    <= '0;
            m_wdata    <= '0;
            for (int i = 0; i < NR; i++) m_busy[i] <= 1'b0;
        end else begin
            if (m_wen) m_busy[m_waddr] <= 1'b0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] <= 1'b1;
            if (exp_alu_ready) begin
                m_wen      <= (alu_rd != 0);
                m_waddr    <= alu_rd;
                m_wdata    <= alu_data;
                m_last_lsu <= 1'b0;
            end else if (exp_lsu_ready) begin
                m_wen      <= (lsu_rd != 0);
                m_waddr    <= lsu_rd;
                m_wdata    <= lsu_data;
                m_last_lsu <= 1'b1;
            end else begin
                m_wen      <= 1'b0;
            end
        end
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("alu_ready", 32'(alu_ready), 32'(exp_alu_ready));
            checkOutput("lsu_ready", 32'(lsu_ready), 32'(exp_lsu_ready));
            checkOutput("hazard",    32'(hazard),    32'(exp_hazard));
            checkOutput("rf_wen",    32'(rf_wen),    32'(m_wen));
            checkOutput("rf_waddr",  32'(rf_waddr),  32'(m_waddr));
            checkOutput("rf_wdata",  rf_wdata,       m_wdata);
        end
    end

    task automatic applyStimulus(input logic av, input logic [AW-1:0] ard,
                                 input logic [DW-1:0] ad, input logic lv,
                                 input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                                 input logic iv, input logic [AW-1:0] ird,
                                 input logic [AW-1:0] c1, input logic [AW-1:0] c2);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
        iss_valid = iv;
        iss_rd    = ird;
        chk_rs1   = c1;
        chk_rs2   = c2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int an;
        int ln;
        bit alu_acc;
        bit lsu_acc;

        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset rf_wen",   32'(rf_wen),   32'd0);
        checkOutput("reset rf_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("reset rf_wdata", rf_wdata,      32'd0);
        checkOutput("reset hazard",   32'(hazard),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] ALU-only write");
        nextCycle();
        applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1 alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("t1 lsu_ready", 32'(lsu_ready), 32'd0);
        checkOutput("t1 rf_wen pre", 32'(rf_wen), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1 rf_wen", 32'(rf_wen), 32'd1);
        checkOutput("t1 rf_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("t1 rf_wdata", rf_wdata, 32'h1234);
        nextCycle();
        @(negedge clk);
        checkOutput("t1 rf_wen post", 32'(rf_wen), 32'd0);
        checkOutput("t1 rf_waddr hold", 32'(rf_waddr), 32'd5);

        $display("[TB] tie after reset");
        nextCycle();
        applyStimulus(1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t2 c0 lsu_ready", 32'(lsu_ready), 32'd1);
        checkOutput("t2 c0 alu_ready", 32'(alu_ready), 32'd0);
        nextCycle();
        applyStimulus(1, 3, 32'hA, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t2 c1 alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("t2 c1 rf_wen", 32'(rf_wen), 32'd1);
        checkOutput("t2 c1 rf_waddr", 32'(rf_waddr), 32'd4);
        checkOutput("t2 c1 rf_wdata", rf_wdata, 32'hB);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t2 c2 rf_waddr", 32'(rf_waddr), 32'd3);
        checkOutput("t2 c2 rf_wdata", rf_wdata, 32'hA);

        $display("[TB] sustained round robin");
        an = 0;
        ln = 0;
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            applyStimulus(1, 10, 32'h100 + 32'(an), 1, 20, 32'h200 + 32'(ln), 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("t3 lsu_ready", 32'(lsu_ready), 32'((i % 2) == 0));
            checkOutput("t3 alu_ready", 32'(alu_ready), 32'((i % 2) == 1));
            if ((i % 2) == 1) an++;
            else              ln++;
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("[TB] scoreboard set and clear");
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        @(negedge clk);
        checkOutput("t4 hazard before", 32'(hazard), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        checkOutput("t4 hazard set", 32'(hazard), 32'd1);
        nextCycle();
        applyStimulus(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        checkOutput("t4 alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("t4 hazard xfer", 32'(hazard), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        checkOutput("t4 rf_wen", 32'(rf_wen), 32'd1);
        checkOutput("t4 rf_waddr", 32'(rf_waddr), 32'd7);
        checkOutput("t4 hazard wen", 32'(hazard), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("t4 hazard cleared", 32'(hazard), 32'd0);

        $display("[TB] same-edge set and clear");
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
        @(negedge clk);
        checkOutput("t5 hazard before", 32'(hazard), 32'd0);
        nextCycle();
        applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 9);
        @(negedge clk);
        checkOutput("t5 hazard set", 32'(hazard), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
        @(negedge clk);
        checkOutput("t5 rf_wen", 32'(rf_wen), 32'd1);
        checkOutput("t5 rf_waddr", 32'(rf_waddr), 32'd9);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        @(negedge clk);
        checkOutput("t5 hazard kept", 32'(hazard), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("t5 hazard still", 32'(hazard), 32'd1);

        $display("[TB] x0 handling and reset mid-flight");
        nextCycle();
        applyStimulus(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 9);
        @(negedge clk);
        checkOutput("t6 x0 alu_ready", 32'(alu_ready), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 9);
        @(negedge clk);
        checkOutput("t6 x0 rf_wen", 32'(rf_wen), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t6 x0 hazard", 32'(hazard), 32'd0);
        nextCycle();
        applyStimulus(1, 12, 32'hC0FFEE, 0, 0, 0, 0, 0, 0, 9);
        @(negedge clk);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        #1;
        checkOutput("t6 rf_wen live", 32'(rf_wen), 32'd1);
        checkOutput("t6 hazard live", 32'(hazard), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 rst rf_wen", 32'(rf_wen), 32'd0);
        checkOutput("t6 rst rf_wdata", rf_wdata, 32'd0);
        checkOutput("t6 rst hazard", 32'(hazard), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 9);
        @(negedge clk);
        checkOutput("t6 tie after reset", 32'(lsu_ready), 32'd1);
        checkOutput("t6 busy cleared", 32'(hazard), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            alu_acc = alu_valid && exp_alu_ready;
            lsu_acc = lsu_valid && exp_lsu_ready;
            nextCycle();
            if (!alu_valid || alu_acc) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rd    = AW'($urandom_range(0, 15));
                alu_data  = $urandom;
            end
            if (!lsu_valid || lsu_acc) begin
                lsu_valid = ($urandom_range(0, 99) < 60);
                lsu_rd    = AW'($urandom_range(0, 15));
                lsu_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_rd    = AW'($urandom_range(0, 15));
            chk_rs1   = AW'($urandom_range(0, 15));
            chk_rs2   = AW'($urandom_range(0, 15));
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single write port of the integer register file between the two writeback sources, ALU/EXU results and LSU load data, using round-robin arbitration.
- Keeps a per-register scoreboard of pending writes so decode can stall on read-after-write hazards.
- Sits between EXU/LSU writeback and the register file write port. Decode drives issue and hazard-check ports.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers, x0 hardwired zero

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle
alu_rd  input  ADDR_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
lsu_valid  input  1  LSU writeback request
lsu_ready  output  1  LSU request accepted this cycle
lsu_rd  input  ADDR_WIDTH  LSU destination register
lsu_data  input  DATA_WIDTH  load data
iss_valid  input  1  decode issues an instruction that writes iss_rd
iss_rd  input  ADDR_WIDTH  destination of issued instruction
chk_rs1  input  ADDR_WIDTH  source 1 to check
chk_rs2  input  ADDR_WIDTH  source 2 to check
hazard  output  1  a checked source has a pending write
rf_wen  output  1  register file write enable (registered)
rf_waddr  output  ADDR_WIDTH  register file write address (registered)
rf_wdata  output  DATA_WIDTH  register file write data (registered)

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All busy bits cleared.
  - last_grant=ALU.
  - In-flight accepted requests are dropped. Reset mid-operation requires no recovery beyond this.
- Arbitration is combinational from the current valids and last_grant:
  - Only one source valid: that source's ready=1.
  - Both valid: grant the source not in last_grant. After reset, the first tie goes to LSU.
  - Never both readies high. Ready is low whenever the corresponding valid is low.
- Handshake: a transfer occurs when valid&&ready. Requesters hold valid, rd and data stable until ready. There is no downstream backpressure, so an ungranted requester waits at most one cycle.
- last_grant updates on every transfer to the granted source, including uncontested ones.
- Output stage, 1-cycle latency from handshake to write:
  - On a transfer: rf_wen <= (rd!=0), rf_waddr <= rd, rf_wdata <= data.
  - With no transfer: rf_wen <= 0; rf_waddr and rf_wdata hold.
  - The register file commits at the edge following the cycle in which rf_wen=1.
- Scoreboard, one busy bit per register:
  - busy[0] is constant 0.
  - Set: iss_valid && iss_rd!=0 sets busy[iss_rd] at the edge.
  - Clear: rf_wen=1 clears busy[rf_waddr] at the edge, i.e. when the write commits.
  - Same-edge set and clear of the same register: set wins, because the new issue supersedes.
  - Issue to an already-busy register keeps it busy. This is single-outstanding tracking: decode must not issue a second writer to a busy rd. Hazard stall enforces this when rd is also checked.
- hazard = (chk_rs1!=0 && busy[chk_rs1]) || (chk_rs2!=0 && busy[chk_rs2]). Combinational, reflects state before the current edge.
  - No forwarding: in the cycle rf_wen=1 for rX, hazard for rX is still 1. It clears the following cycle, when the file read returns new data.
- Writes to x0 are accepted and consumed, but produce rf_wen=0 and never touch the scoreboard.

Test Plan:
1. Reset, then ALU-only request: alu_valid=1, alu_rd=5, alu_data=0x1234 -> alu_ready=1 same cycle. Next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234. Following cycle rf_wen=0.
2. Tie after reset: both valid, alu_rd=3/0xA, lsu_rd=4/0xB, held -> cycle0 lsu_ready=1. Cycle1 alu_ready=1 and rf write x4=0xB. Cycle2 rf write x3=0xA.
3. Round-robin sustained: both valid held for 6 cycles -> grants alternate LSU, ALU, LSU, ALU, ... with no double grant and no source starving.
4. Scoreboard:
   - iss_valid, iss_rd=7; chk_rs1=7 -> hazard=1 from next cycle.
   - ALU writes x7 -> hazard stays 1 through the rf_wen cycle, then 0 the cycle after.
5. Same-edge set/clear: rf_wen=1 for x9 and iss_valid, iss_rd=9 in the same cycle -> busy[9] remains 1, hazard on chk_rs2=9 stays 1.
6. x0 and reset mid-flight:
   - alu_rd=0 -> alu_ready=1, rf_wen stays 0.
   - iss_rd=0 -> hazard for chk_rs1=0 always 0.
   - Assert rst_n=0 while rf_wen=1 -> rf_wen=0 immediately and all busy bits clear.
